gf_br_resolve_q: RTL and testbench

In-order branch resolution queue that drives the pattern history table's update port. Fetch pushes each predicted branch: address, predicted direction and predicted target. Execute resolves branches oldest-first; this block pops the matching entry and emits a registered PHT update (address, taken, is-branch strobe). On a wrong prediction it raises a redirect and flushes all younger entries.

---
 rtl/gf_bp_pkg.sv | 19 +
 rtl/gf_br_fifo.sv | 72 +++++++
 rtl/gf_br_resolve_q.sv | 92 +++++++++
 tb/tb_gf_br_resolve_q.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gf_bp_pkg.sv
// Shared branch-predictor types and constants.
package gf_bp_pkg;

    // Fixed instruction size; the fall-through address is inst_addr + INST_BYTES.
    localparam int INST_BYTES  = 4;

    // Widest address any instantiating module may use. Modules with a
    // narrower ADDR_LEN store their addresses in the low ADDR_LEN bits.
    localparam int BP_ADDR_MAX = 64;

    typedef logic [BP_ADDR_MAX-1:0] bp_addr_t;

    typedef struct packed {
        bp_addr_t inst_addr;
        bp_addr_t target;
        logic     pred_taken;
    } br_entry_t;

endpackage

// File: rtl/gf_br_fifo.sv
// Circular buffer of predicted branches with flush support.
// A flush pops the head and discards every younger entry in one cycle.
module gf_br_fifo
    import gf_bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,      // caller guarantees queue is non-empty
    input  logic             flush,    // only asserted together with pop
    input  br_entry_t        wr_data,
    output br_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    br_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_nxt;
    logic             push_ok;

    // Full gates fetch; flush drops wrong-path pushes.
    assign push_ok = push & ~full & ~flush;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Next occupancy: flush empties, otherwise net of push and pop.
    always_comb begin
        cnt_nxt = count;
        if (flush)
            cnt_nxt = '0;
        else if (push_ok && !pop)
            cnt_nxt = count + CNT_W'(1);
        else if (!push_ok && pop)
            cnt_nxt = count - CNT_W'(1);
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers, count and registered full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (flush) begin
                // Head leaves and the writer restarts right behind it.
                rd_ptr <= rd_ptr + PTR_W'(1);
                wr_ptr <= rd_ptr + PTR_W'(1);
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= cnt_nxt;
            full  <= (cnt_nxt == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/gf_br_resolve_q.sv
// In-order branch resolution queue: pops the oldest prediction on resolve,
// emits a registered PHT update, and redirects/flushes on a mispredict.
module gf_br_resolve_q
    import gf_bp_pkg::*;
#(
    parameter int ADDR_LEN = 64,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_sig_pred_push,
    input  logic [ADDR_LEN-1:0] i_pred_inst_addr,
    input  logic [ADDR_LEN-1:0] i_pred_target,
    input  logic                i_sig_pred_taken,
    output logic                o_sig_full,
    output logic [CNT_W-1:0]    o_count,
    input  logic                i_sig_res_valid,
    input  logic                i_sig_res_taken,
    input  logic [ADDR_LEN-1:0] i_res_target,
    output logic [ADDR_LEN-1:0] o_cur_inst_addr,
    output logic                o_sig_cur_b_taken,
    output logic                o_sig_cur_is_b,
    output logic                o_sig_mispred,
    output logic [ADDR_LEN-1:0] o_redirect_addr
);

    br_entry_t           wr_entry;
    br_entry_t           head;
    logic                empty;
    logic                pop;
    logic                mispred;
    logic                flush;
    logic [ADDR_LEN-1:0] head_addr;
    logic [ADDR_LEN-1:0] head_tgt;
    logic [ADDR_LEN-1:0] redirect;

    // Addresses live in the low ADDR_LEN bits of the shared entry type.
    always_comb begin
        wr_entry            = '0;
        wr_entry.inst_addr  = bp_addr_t'(i_pred_inst_addr);
        wr_entry.target     = bp_addr_t'(i_pred_target);
        wr_entry.pred_taken = i_sig_pred_taken;
    end

    assign head_addr = head.inst_addr[ADDR_LEN-1:0];
    assign head_tgt  = head.target[ADDR_LEN-1:0];

    // A resolve with nothing queued (even with a same-cycle push) is ignored.
    assign pop     = i_sig_res_valid & ~empty;
    assign mispred = (head.pred_taken != i_sig_res_taken) |
                     (head.pred_taken & i_sig_res_taken & (head_tgt != i_res_target));
    assign flush   = pop & mispred;
    assign redirect = i_sig_res_taken ? i_res_target
                                      : head_addr + ADDR_LEN'(INST_BYTES);

    gf_br_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (i_sig_pred_push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (wr_entry),
        .head    (head),
        .count   (o_count),
        .full    (o_sig_full),
        .empty   (empty)
    );

    // PHT update and redirect registers; payload holds between pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cur_inst_addr   <= '0;
            o_sig_cur_b_taken <= 1'b0;
            o_sig_cur_is_b    <= 1'b0;
            o_sig_mispred     <= 1'b0;
            o_redirect_addr   <= '0;
        end else begin
            o_sig_cur_is_b <= pop;
            o_sig_mispred  <= flush;
            if (pop) begin
                o_cur_inst_addr   <= head_addr;
                o_sig_cur_b_taken <= i_sig_res_taken;
                o_redirect_addr   <= redirect;
            end
        end
    end

endmodule

// File: tb/tb_gf_br_resolve_q.sv
// Directed bench for gf_br_resolve_q (ADDR_LEN=64, DEPTH=8).
module tb_gf_br_resolve_q;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_sig_pred_push;
    logic [63:0] i_pred_inst_addr;
    logic [63:0] i_pred_target;
    logic        i_sig_pred_taken;
    logic        o_sig_full;
    logic [3:0]  o_count;
    logic        i_sig_res_valid;
    logic        i_sig_res_taken;
    logic [63:0] i_res_target;
    logic [63:0] o_cur_inst_addr;
    logic        o_sig_cur_b_taken;
    logic        o_sig_cur_is_b;
    logic        o_sig_mispred;
    logic [63:0] o_redirect_addr;

    int errors = 0;
    int checks = 0;

    gf_br_resolve_q #(.ADDR_LEN(64), .DEPTH(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_sig_pred_push   (i_sig_pred_push),
        .i_pred_inst_addr  (i_pred_inst_addr),
        .i_pred_target     (i_pred_target),
        .i_sig_pred_taken  (i_sig_pred_taken),
        .o_sig_full        (o_sig_full),
        .o_count           (o_count),
        .i_sig_res_valid   (i_sig_res_valid),
        .i_sig_res_taken   (i_sig_res_taken),
        .i_res_target      (i_res_target),
        .o_cur_inst_addr   (o_cur_inst_addr),
        .o_sig_cur_b_taken (o_sig_cur_b_taken),
        .o_sig_cur_is_b    (o_sig_cur_is_b),
        .o_sig_mispred     (o_sig_mispred),
        .o_redirect_addr   (o_redirect_addr)
    );

    always #5 clk = ~clk;

    task automatic idle();
        i_sig_pred_push  = 1'b0;
        i_pred_inst_addr = '0;
        i_pred_target    = '0;
        i_sig_pred_taken = 1'b0;
        i_sig_res_valid  = 1'b0;
        i_sig_res_taken  = 1'b0;
        i_res_target     = '0;
    endtask

    task automatic set_push(input logic [63:0] a, input logic [63:0] t, input logic tk);
        i_sig_pred_push  = 1'b1;
        i_pred_inst_addr = a;
        i_pred_target    = t;
        i_sig_pred_taken = tk;
    endtask

    task automatic set_res(input logic tk, input logic [63:0] t);
        i_sig_res_valid = 1'b1;
        i_sig_res_taken = tk;
        i_res_target    = t;
    endtask

    // Apply current inputs at the next rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
        checks++; if (o_sig_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", o_sig_full); end
        checks++; if (o_sig_cur_is_b !== 1'b0 || o_sig_mispred !== 1'b0 || o_sig_cur_b_taken !== 1'b0) begin
            errors++; $display("FAIL reset_strobes got is_b=%b mis=%b tk=%b want 0", o_sig_cur_is_b, o_sig_mispred, o_sig_cur_b_taken); end
        checks++; if (o_cur_inst_addr !== 64'd0 || o_redirect_addr !== 64'd0) begin
            errors++; $display("FAIL reset_addr got %h/%h want 0", o_cur_inst_addr, o_redirect_addr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        set_push(64'h1000, 64'h2000, 1'b1);
        tick();
        checks++; if (o_count !== 4'd1) begin errors++; $display("FAIL basic_count got %0d want 1", o_count); end
        checks++; if (o_sig_cur_is_b !== 1'b0) begin errors++; $display("FAIL basic_no_early got %b want 0", o_sig_cur_is_b); end
        set_res(1'b1, 64'h2000);
        tick();
        checks++; if (o_sig_cur_is_b !== 1'b1 || o_cur_inst_addr !== 64'h1000 || o_sig_cur_b_taken !== 1'b1) begin
            errors++; $display("FAIL basic_update got is_b=%b addr=%h tk=%b want 1/1000/1", o_sig_cur_is_b, o_cur_inst_addr, o_sig_cur_b_taken); end
        checks++; if (o_sig_mispred !== 1'b0) begin errors++; $display("FAIL basic_mispred got %b want 0", o_sig_mispred); end
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL basic_count_pop got %0d want 0", o_count); end
        tick();
        checks++; if (o_sig_cur_is_b !== 1'b0 || o_cur_inst_addr !== 64'h1000) begin
            errors++; $display("FAIL basic_one_cycle got is_b=%b addr=%h want 0/1000", o_sig_cur_is_b, o_cur_inst_addr); end
    endtask

    task automatic test_mispred();
        // Predicted not-taken, actually taken.
        set_push(64'h1000, 64'h0, 1'b0); tick();
        set_res(1'b1, 64'h3000); tick();
        checks++; if (o_sig_mispred !== 1'b1 || o_redirect_addr !== 64'h3000) begin
            errors++; $display("FAIL mis_nt_t got mis=%b rd=%h want 1/3000", o_sig_mispred, o_redirect_addr); end
        tick();
        checks++; if (o_sig_mispred !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got %b want 0", o_sig_mispred); end
        // Predicted taken, actually not-taken: fall through.
        set_push(64'h1000, 64'h2000, 1'b1); tick();
        set_res(1'b0, 64'h0); tick();
        checks++; if (o_sig_mispred !== 1'b1 || o_redirect_addr !== 64'h1004 || o_sig_cur_b_taken !== 1'b0) begin
            errors++; $display("FAIL mis_t_nt got mis=%b rd=%h tk=%b want 1/1004/0", o_sig_mispred, o_redirect_addr, o_sig_cur_b_taken); end
        // Taken both ways but wrong target.
        set_push(64'h1000, 64'h2000, 1'b1); tick();
        set_res(1'b1, 64'h2400); tick();
        checks++; if (o_sig_mispred !== 1'b1 || o_redirect_addr !== 64'h2400) begin
            errors++; $display("FAIL mis_target got mis=%b rd=%h want 1/2400", o_sig_mispred, o_redirect_addr); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 8; i++) begin
            set_push(64'h100 + 64'(4 * i), 64'h0, 1'b0);
            tick();
        end
        checks++; if (o_count !== 4'd8 || o_sig_full !== 1'b1) begin
            errors++; $display("FAIL full_fill got cnt=%0d full=%b want 8/1", o_count, o_sig_full); end
        set_push(64'hDEAD, 64'h0, 1'b0); tick();
        checks++; if (o_count !== 4'd8) begin errors++; $display("FAIL full_drop got %0d want 8", o_count); end
        // Pop while full: the push is gated by full, so occupancy drops by one.
        set_push(64'hBEEF, 64'h0, 1'b0); set_res(1'b0, 64'h0); tick();
        checks++; if (o_sig_cur_is_b !== 1'b1 || o_cur_inst_addr !== 64'h100 || o_sig_mispred !== 1'b0) begin
            errors++; $display("FAIL full_pop0 got is_b=%b addr=%h mis=%b want 1/100/0", o_sig_cur_is_b, o_cur_inst_addr, o_sig_mispred); end
        checks++; if (o_count !== 4'd7 || o_sig_full !== 1'b0) begin
            errors++; $display("FAIL full_pushpop got cnt=%0d full=%b want 7/0", o_count, o_sig_full); end
        for (int i = 1; i < 8; i++) begin
            set_res(1'b0, 64'h0); tick();
            checks++; if (o_sig_cur_is_b !== 1'b1 || o_cur_inst_addr !== 64'h100 + 64'(4 * i)) begin
                errors++; $display("FAIL full_order%0d got is_b=%b addr=%h want 1/%h", i, o_sig_cur_is_b, o_cur_inst_addr, 64'h100 + 64'(4 * i)); end
        end
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL full_drain got %0d want 0", o_count); end
        // Neither dropped push was stored.
        set_res(1'b0, 64'h0); tick();
        checks++; if (o_sig_cur_is_b !== 1'b0) begin errors++; $display("FAIL full_no_extra got %b want 0", o_sig_cur_is_b); end
    endtask

    task automatic test_flush();
        set_push(64'h500, 64'h0, 1'b0); tick();
        set_push(64'h504, 64'h0, 1'b0); tick();
        set_push(64'h508, 64'h0, 1'b0); tick();
        set_res(1'b1, 64'h9000); set_push(64'h600, 64'h0, 1'b0); tick();
        checks++; if (o_sig_mispred !== 1'b1 || o_cur_inst_addr !== 64'h500 || o_redirect_addr !== 64'h9000) begin
            errors++; $display("FAIL flush_mis got mis=%b addr=%h rd=%h want 1/500/9000", o_sig_mispred, o_cur_inst_addr, o_redirect_addr); end
        checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", o_count); end
        set_res(1'b0, 64'h0); tick();
        checks++; if (o_sig_cur_is_b !== 1'b0 || o_sig_mispred !== 1'b0) begin
            errors++; $display("FAIL flush_after got is_b=%b mis=%b want 0/0", o_sig_cur_is_b, o_sig_mispred); end
    endtask

    task automatic test_empty_resolve();
        set_res(1'b1, 64'h7000); set_push(64'h800, 64'h0, 1'b0); tick();
        checks++; if (o_sig_cur_is_b !== 1'b0 || o_sig_mispred !== 1'b0) begin
            errors++; $display("FAIL empty_res got is_b=%b mis=%b want 0/0", o_sig_cur_is_b, o_sig_mispred); end
        checks++; if (o_count !== 4'd1) begin errors++; $display("FAIL empty_push got %0d want 1", o_count); end
        set_res(1'b0, 64'h0); tick();
        checks++; if (o_sig_cur_is_b !== 1'b1 || o_cur_inst_addr !== 64'h800) begin
            errors++; $display("FAIL empty_pop got is_b=%b addr=%h want 1/800", o_sig_cur_is_b, o_cur_inst_addr); end
    endtask

    task automatic test_back_to_back();
        set_push(64'hA00, 64'h0, 1'b0); tick();
        set_push(64'hA04, 64'h0, 1'b0); tick();
        set_res(1'b0, 64'h0); set_push(64'hA08, 64'h0, 1'b0); tick();
        checks++; if (o_sig_cur_is_b !== 1'b1 || o_cur_inst_addr !== 64'hA00 || o_count !== 4'd2) begin
            errors++; $display("FAIL b2b_0 got is_b=%b addr=%h cnt=%0d want 1/a00/2", o_sig_cur_is_b, o_cur_inst_addr, o_count); end
        set_res(1'b0, 64'h0); tick();
        checks++; if (o_sig_cur_is_b !== 1'b1 || o_cur_inst_addr !== 64'hA04) begin
            errors++; $display("FAIL b2b_1 got is_b=%b addr=%h want 1/a04", o_sig_cur_is_b, o_cur_inst_addr); end
        set_res(1'b0, 64'h0); tick();
        checks++; if (o_sig_cur_is_b !== 1'b1 || o_cur_inst_addr !== 64'hA08 || o_count !== 4'd0) begin
            errors++; $display("FAIL b2b_2 got is_b=%b addr=%h cnt=%0d want 1/a08/0", o_sig_cur_is_b, o_cur_inst_addr, o_count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            set_push(64'hC00 + 64'(4 * i), 64'h0, 1'b0);
            tick();
        end
        set_res(1'b0, 64'h0); set_push(64'hC10, 64'h0, 1'b0); tick();
        checks++; if (o_count !== 4'd4 || o_sig_cur_is_b !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got cnt=%0d is_b=%b want 4/1", o_count, o_sig_cur_is_b); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_count !== 4'd0 || o_sig_full !== 1'b0 || o_sig_cur_is_b !== 1'b0 || o_sig_mispred !== 1'b0) begin
            errors++; $display("FAIL rstmid got cnt=%0d full=%b is_b=%b mis=%b want 0", o_count, o_sig_full, o_sig_cur_is_b, o_sig_mispred); end
        @(negedge clk);
        rst_n = 1'b1;
        set_res(1'b0, 64'h0); tick();
        checks++; if (o_sig_cur_is_b !== 1'b0) begin errors++; $display("FAIL rstmid_empty got %b want 0", o_sig_cur_is_b); end
    endtask

    task automatic test_wrap_addr();
        set_push(64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 1'b1); tick();
        set_res(1'b0, 64'h0); tick();
        checks++; if (o_sig_mispred !== 1'b1 || o_redirect_addr !== 64'h0) begin
            errors++; $display("FAIL addr_wrap got mis=%b rd=%h want 1/0", o_sig_mispred, o_redirect_addr); end
        checks++; if (o_cur_inst_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++; $display("FAIL addr_wrap_pht got %h want fffffffffffffffc", o_cur_inst_addr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mispred();
        test_full_wrap();
        test_flush();
        test_empty_resolve();
        test_back_to_back();
        test_reset_mid();
        test_wrap_addr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
